// File: rtl/lfsr_pkg.sv
// Shared types and constants for the lfsr_gen pseudo-random generator slice.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FREE  = 2'd1,
    BURST = 2'd2
  } lfsr_state_e;

  // Maximal-length Galois feedback masks for common widths
  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

endpackage

// File: rtl/lfsr_gen_if.sv
// Valid/ready stream carrying random words from lfsr_gen to its consumer.
interface lfsr_gen_if #(
  parameter int OUT_W = 8
);
  logic             rnd_valid;
  logic             rnd_ready;
  logic [OUT_W-1:0] rnd_data;

  modport master (output rnd_valid, output rnd_data, input rnd_ready);
  modport slave  (input rnd_valid, input rnd_data, output rnd_ready);
endinterface

// File: rtl/lfsr_step.sv
// Combinational Galois LFSR advance by NSTEPS single steps (right shift, zero fill,
// XOR TAPS when the shifted-out bit is 1).
module lfsr_step #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
  parameter int               NSTEPS = 1
) (
  input  logic [WIDTH-1:0] cur_state_s,
  output logic [WIDTH-1:0] nxt_state_s
);

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
    return {1'b0, s[WIDTH-1:1]} ^ (s[0] ? TAPS : {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0] chain_s;

  // Unrolled chain of single steps, all within one cycle
  always_comb begin
    chain_s = cur_state_s;
    for (int i = 0; i < NSTEPS; i++) begin
      chain_s = step1(chain_s);
    end
    nxt_state_s = chain_s;
  end

endmodule

// File: rtl/lfsr_gen.sv
// Seedable Galois LFSR generator with free-run / counted-burst stream output.
// Build option LFSR_LEAP_EN: advance OUT_W steps per handshake instead of one.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W16,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'h0001,
  parameter int               OUT_W        = 8,
  parameter int               CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] burst_len,
  lfsr_gen_if.master       rnd,
  output logic             busy,
  output logic             done,
  output logic             lockup,
  input  logic             lockup_clr
);

`ifdef LFSR_LEAP_EN
  localparam int NSTEPS = OUT_W;
`else
  localparam int NSTEPS = 1;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  lfsr_state_e      fsm_r, fsm_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] state_r, state_s, step_s;
  logic             run_r, done_r, done_s, lockup_r, lockup_s;
  logic             hs_s, seed_zero_s;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .NSTEPS(NSTEPS)
  ) u_step (
    .cur_state_s(state_r),
    .nxt_state_s(step_s)
  );

  assign hs_s        = run_r & rnd.rnd_ready;
  assign seed_zero_s = (seed == {WIDTH{1'b0}});

  // Run control: start/stop commands, burst counting and done generation
  always_comb begin
    fsm_s  = fsm_r;
    cnt_s  = cnt_r;
    done_s = 1'b0;
    case (fsm_r)
      IDLE: begin
        if (start && !stop) begin
          if (!mode) begin
            fsm_s = FREE;
          end else if (burst_len != {CNT_W{1'b0}}) begin
            fsm_s = BURST;
            cnt_s = burst_len;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          fsm_s = IDLE;
        end
      end
      FREE: begin
        if (stop) fsm_s = IDLE;
        else      fsm_s = FREE;
      end
      BURST: begin
        // The last accepted word completes the burst even when stop coincides
        if (hs_s) begin
          cnt_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            fsm_s  = IDLE;
            done_s = 1'b1;
          end else if (stop) begin
            fsm_s = IDLE;
          end else begin
            fsm_s = BURST;
          end
        end else if (stop) begin
          fsm_s = IDLE;
        end else begin
          fsm_s = BURST;
        end
      end
      default: begin
        fsm_s = IDLE;
      end
    endcase
  end

  // Generator state and sticky lockup flag; a seed load beats a same-cycle step
  always_comb begin
    if (seed_we) begin
      state_s = seed_zero_s ? SEED_DEFAULT : seed;
    end else if (hs_s) begin
      state_s = step_s;
    end else begin
      state_s = state_r;
    end

    if (seed_we && seed_zero_s) begin
      lockup_s = 1'b1;
    end else if (lockup_clr) begin
      lockup_s = 1'b0;
    end else begin
      lockup_s = lockup_r;
    end
  end

  // Registers, including the registered stream/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r    <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      state_r  <= SEED_DEFAULT;
      run_r    <= 1'b0;
      done_r   <= 1'b0;
      lockup_r <= 1'b0;
    end else begin
      fsm_r    <= fsm_s;
      cnt_r    <= cnt_s;
      state_r  <= state_s;
      run_r    <= (fsm_s != IDLE);
      done_r   <= done_s;
      lockup_r <= lockup_s;
    end
  end

  assign rnd.rnd_valid = run_r;
  assign rnd.rnd_data  = state_r[OUT_W-1:0];
  assign busy          = run_r;
  assign done          = done_r;
  assign lockup        = lockup_r;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a transaction-level reference predicts every cycle's
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_lfsr_gen;

  localparam int W  = 16;
  localparam int OW = 8;
  localparam int CW = 8;
`ifdef LFSR_LEAP_EN
  localparam int NST = OW;
`else
  localparam int NST = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, seed_we, mode, start, stop, lockup_clr, busy, done, lockup;
  logic [W-1:0]  seed;
  logic [CW-1:0] burst_len;
  lfsr_gen_if #(.OUT_W(OW)) rnd_if ();

  lfsr_gen dut (
    .clk(clk), .rst_n(rst_n), .seed_we(seed_we), .seed(seed), .mode(mode),
    .start(start), .stop(stop), .burst_len(burst_len), .rnd(rnd_if),
    .busy(busy), .done(done), .lockup(lockup), .lockup_clr(lockup_clr)
  );

  // Small 4-bit instance for the full-period property
  logic       p_seed_we, p_mode, p_start, p_stop, p_lockup_clr, p_busy, p_done, p_lockup;
  logic [3:0] p_seed;
  logic [4:0] p_burst_len;
  lfsr_gen_if #(.OUT_W(4)) p_if ();

  lfsr_gen #(
    .WIDTH(4), .TAPS(4'hC), .SEED_DEFAULT(4'h1), .OUT_W(4), .CNT_W(5)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .seed_we(p_seed_we), .seed(p_seed), .mode(p_mode),
    .start(p_start), .stop(p_stop), .burst_len(p_burst_len), .rnd(p_if),
    .busy(p_busy), .done(p_done), .lockup(p_lockup), .lockup_clr(p_lockup_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit valid;
    bit done;
    bit lock;
    int data;
  } exp_t;
  exp_t exp_q[$];

  // Reference: run kind (0 none, 1 free, 2 burst), words left, generator state
  int m_state, m_run, m_left;
  bit m_done, m_lock;

  function automatic int step_n(input int s);
    int v = s;
    for (int k = 0; k < NST; k++) v = (v >> 1) ^ (((v & 1) != 0) ? 'hB400 : 0);
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 1; m_run = 0; m_left = 0; m_done = 0; m_lock = 0;
  endtask

  // Publish this cycle's expected outputs, advance the reference, wait one clock
  task automatic tick();
    exp_t e;
    bit hs, nd;
    int nxt;
    e.valid = (m_run != 0);
    e.done  = m_done;
    e.lock  = m_lock;
    e.data  = m_state & 'hFF;
    exp_q.push_back(e);
    if (!rst_n) begin
      model_reset();
    end else begin
      hs = (m_run != 0) && rnd_if.rnd_ready;
      nd = 0;
      if (seed_we)  nxt = (seed == 0) ? 1 : int'(seed);
      else if (hs)  nxt = step_n(m_state);
      else          nxt = m_state;
      if (seed_we && seed == 0) m_lock = 1;
      else if (lockup_clr)      m_lock = 0;
      if (m_run == 0) begin
        if (start && !stop) begin
          if (!mode)               m_run = 1;
          else if (burst_len != 0) begin m_run = 2; m_left = burst_len; end
          else                     nd = 1;
        end
      end else if (m_run == 1) begin
        if (stop) m_run = 0;
      end else begin
        if (hs) begin
          m_left--;
          if (m_left == 0) begin m_run = 0; nd = 1; end
          else if (stop)   m_run = 0;
        end else if (stop) m_run = 0;
      end
      m_state = nxt;
      m_done  = nd;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the queued prediction
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rnd_valid", int'(rnd_if.rnd_valid), int'(e.valid));
      check("busy",      int'(busy),             int'(e.valid));
      check("done",      int'(done),             int'(e.done));
      check("lockup",    int'(lockup),           int'(e.lock));
      check("rnd_data",  int'(rnd_if.rnd_data),  e.data);
    end
  end

  initial begin
    int hs_cnt, done_cnt;
    rst_n = 1'b0; seed_we = 1'b0; seed = 16'h0000; mode = 1'b0; start = 1'b0;
    stop = 1'b0; burst_len = 8'd0; lockup_clr = 1'b0; rnd_if.rnd_ready = 1'b0;
    p_seed_we = 1'b0; p_seed = 4'h0; p_mode = 1'b0; p_start = 1'b0; p_stop = 1'b0;
    p_burst_len = 5'd0; p_lockup_clr = 1'b0; p_if.rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    check("reset_valid", int'(rnd_if.rnd_valid), 0);
    check("reset_data",  int'(rnd_if.rnd_data), 'h01);

    // Single-step sequence from seed ACE1
    seed_we = 1'b1; seed = 16'hACE1; tick(); seed_we = 1'b0;
    check("seed_data", int'(rnd_if.rnd_data), 'hE1);
    mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
    check("start_latency", int'(rnd_if.rnd_valid), 1);
    rnd_if.rnd_ready = 1'b1;
`ifdef LFSR_LEAP_EN
    tick(); check("leap_word", int'(rnd_if.rnd_data), 'hC4);
`else
    tick(); check("seq_w1", int'(rnd_if.rnd_data), 'h70);
    tick(); check("seq_w2", int'(rnd_if.rnd_data), 'h38);
    tick(); check("seq_w3", int'(rnd_if.rnd_data), 'h9C);
`endif
    // Backpressure holds the word
    rnd_if.rnd_ready = 1'b0;
    repeat (5) tick();
    stop = 1'b1; tick(); stop = 1'b0;

    // Burst of 3
    mode = 1'b1; burst_len = 8'd3; start = 1'b1; rnd_if.rnd_ready = 1'b1;
    tick(); start = 1'b0;
    hs_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (rnd_if.rnd_valid && rnd_if.rnd_ready) hs_cnt++;
      if (done) done_cnt++;
      tick();
    end
    check("burst3_handshakes", hs_cnt, 3);
    check("burst3_done_count", done_cnt, 1);
    check("burst3_busy", int'(busy), 0);

    // Zero-length burst and stop priority
    burst_len = 8'd0; start = 1'b1; tick(); start = 1'b0;
    check("burst0_done", int'(done), 1);
    check("burst0_valid", int'(rnd_if.rnd_valid), 0);
    burst_len = 8'd4; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("start_stop_idle", int'(busy), 0);

    // Stop mid-burst
    burst_len = 8'd10; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (3) tick();

    // Lockup set, simultaneous set/clear, clear
    seed_we = 1'b1; seed = 16'h0000; tick(); seed_we = 1'b0;
    check("lockup_set", int'(lockup), 1);
    check("lockup_data", int'(rnd_if.rnd_data), 'h01);
    seed_we = 1'b1; lockup_clr = 1'b1; tick(); seed_we = 1'b0;
    check("lockup_set_wins", int'(lockup), 1);
    tick(); lockup_clr = 1'b0;
    check("lockup_clr", int'(lockup), 0);

    // Full period of the 4-bit instance
    p_seed_we = 1'b1; p_seed = 4'h1; tick(); p_seed_we = 1'b0;
    p_mode = 1'b1; p_burst_len = 5'd15; p_start = 1'b1; tick(); p_start = 1'b0;
    p_if.rnd_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("period_nonzero", int'(p_if.rnd_data == 4'h0), 0);
      check("period_return", int'(p_if.rnd_data == 4'h1), int'(i == 15));
    end
    p_if.rnd_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n            = ($urandom_range(0, 299) != 0);
      seed_we          = ($urandom_range(0, 15) == 0);
      seed             = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      mode             = 1'($urandom_range(0, 1));
      start            = ($urandom_range(0, 7) == 0);
      stop             = ($urandom_range(0, 19) == 0);
      burst_len        = 8'($urandom_range(0, 6));
      lockup_clr       = ($urandom_range(0, 15) == 0);
      rnd_if.rnd_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst_n = 1'b1; seed_we = 1'b0; start = 1'b0; stop = 1'b0; lockup_clr = 1'b0;
    tick();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
